// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - shared ALU op codes, flag struct and default sizes
package cla_pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  function automatic logic op_inverts_b(alu_op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  function automatic logic op_carry_in(alu_op_e op, logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/cla_seg.sv
// rtl/cla_seg.sv - SEG-bit combinational carry-lookahead adder built from 4-bit groups
module cla_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  localparam int GROUPS = SEG / 4;

  logic [SEG-1:0]  gen;
  logic [SEG-1:0]  prop;
  logic [SEG-1:0]  carry;
  logic [GROUPS:0] group_c;
  logic            gpre;
  logic            ppre;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // gpre/ppre accumulate the group-local prefix, so each bit carry is G | P & group_cin
  always_comb begin
    carry      = '0;
    group_c    = '0;
    gpre       = 1'b0;
    ppre       = 1'b1;
    group_c[0] = cin_i;
    for (int gi = 0; gi < GROUPS; gi++) begin
      gpre = 1'b0;
      ppre = 1'b1;
      for (int j = 0; j < 4; j++) begin
        carry[4*gi+j] = gpre | (ppre & group_c[gi]);
        gpre          = gen[4*gi+j] | (prop[4*gi+j] & gpre);
        ppre          = ppre & prop[4*gi+j];
      end
      group_c[gi+1] = gpre | (ppre & group_c[gi]);
    end
  end

  assign sum_o  = prop ^ carry;
  assign cout_o = group_c[GROUPS];
  assign cmsb_o = carry[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined CLA add/sub, one SEG-bit segment per stage, global stall
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of SEG");
  end
  if ((SEG % 4) != 0) begin : g_bad_seg
    $error("cla_pipe_adder: SEG must be a multiple of 4");
  end

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             z_q [STAGES];
  logic             v_q [STAGES];
  logic             cm_q[STAGES];

  logic [WIDTH-1:0] a_src[STAGES];
  logic [WIDTH-1:0] b_src[STAGES];
  logic [WIDTH-1:0] s_src[STAGES];
  logic             c_src[STAGES];
  logic             z_src[STAGES];
  logic             v_src[STAGES];

  logic [WIDTH-1:0] s_d[STAGES];
  logic             z_d[STAGES];

  logic [SEG-1:0]   seg_sum[STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  alu_op_e          op;
  logic             advance;
  alu_flags_t       flags;

  assign op       = alu_op_e'(in_op);
  assign advance  = out_ready | ~v_q[LAST];
  assign in_ready = advance;

  always_comb begin
    a_src[0] = in_a;
    b_src[0] = op_inverts_b(op) ? ~in_b : in_b;
    s_src[0] = '0;
    c_src[0] = op_carry_in(op, in_cin);
    z_src[0] = 1'b1;
    v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      z_src[k] = z_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_seg #(.SEG(SEG)) u_seg (
      .a_i   (a_src[k][k*SEG +: SEG]),
      .b_i   (b_src[k][k*SEG +: SEG]),
      .cin_i (c_src[k]),
      .sum_o (seg_sum[k]),
      .cout_o(seg_co[k]),
      .cmsb_o(seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k]                = s_src[k];
      s_d[k][k*SEG +: SEG]  = seg_sum[k];
      z_d[k]                = z_src[k] & ~|seg_sum[k];
    end
  end

  // Data registers reset too, so out_sum and flags read 0 straight after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        z_q[k]  <= 1'b0;
        cm_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= v_src[k];
        a_q[k]  <= a_src[k];
        b_q[k]  <= b_src[k];
        s_q[k]  <= s_d[k];
        c_q[k]  <= seg_co[k];
        z_q[k]  <= z_d[k];
        cm_q[k] <= seg_cm[k];
      end
    end
  end

  assign flags = '{cout: c_q[LAST],
                   ovf:  c_q[LAST] ^ cm_q[LAST],
                   zero: z_q[LAST],
                   neg:  s_q[LAST][WIDTH-1]};

  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_cout  = flags.cout;
  assign out_ovf   = flags.ovf;
  assign out_zero  = flags.zero;
  assign out_neg   = flags.neg;

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU. It replaces the fixed 32-bit combinational adder and splits a WIDTH-bit add into STAGES segments of SEG bits, with one registered segment per clock. The block accepts one operation per cycle under a valid/ready handshake and returns the sum with carry, overflow, zero and negative flags. It sits between the ALU operand latches and the result/flag register.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SEG.
- SEG, 8, segment width; must be a multiple of 4.
- STAGES, WIDTH/SEG, derived pipeline depth; not overridable.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts this cycle.
- in_op  in  2  operation select: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry in, used by ADC and SBC only.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of the MSB.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum equals 0.
- out_neg  out  1  out_sum[WIDTH-1].

## Operation
- **Effective operands:**
  - ADD: B' = B, c0 = 0.
  - ADC: B' = B, c0 = in_cin.
  - SUB: B' = ~B, c0 = 1.
  - SBC: B' = ~B, c0 = in_cin (carry means no borrow).
- **Stage k (0..STAGES-1):**
  - Adds segment k of A and B' with the carry registered by stage k-1 (stage 0 uses c0).
  - Registers the segment sum, the carry out, a running zero flag and the not-yet-added upper segments of A and B'.
- **Flags from the final stage:**
  - out_cout = carry out of segment STAGES-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = AND of all per-segment zero bits.
  - out_neg = out_sum[WIDTH-1].
- **Arithmetic:**
  - Modulo 2^WIDTH with no saturation.
  - SUB of equal operands gives sum 0, cout 1, zero 1.
- **Flow control:**
  - The pipeline uses a global stall: advance = out_ready OR NOT out_valid.
  - in_ready = advance.
  - A transfer occurs on in_valid AND in_ready. When advance is high and in_valid is low, a bubble (valid 0) enters.
  - During a stall every stage register holds, and out_* stay stable until accepted.
- **Ordering:** results leave in acceptance order. The block never drops or duplicates an operation.

## Timing
- **Latency:** an operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following the STAGES-th edge counting the acceptance edge as the first. With defaults this is 4 cycles.
- **Throughput:** one operation per cycle while out_ready is held high.
- **Reset:**
  - All valid bits clear. out_valid = 0, out_sum = 0 and all flags = 0.
  - in_ready = 1 in the first cycle after reset.
- **Reset mid-operation:** all in-flight operations are discarded, and no partial result is ever presented.
- **Simultaneous accept in and accept out:** both occur in the same cycle with no bubble inserted.
- **out_ready low with the pipe full:** in_ready = 0 in the same cycle (combinational), and the next input is held by the producer.
- **Zero-latency paths:** none from in_* to out_*. in_ready depends combinationally only on out_ready and out_valid.

## Structure
- **Shared ALU package:**
  - Op encodings (OP_ADD, OP_ADC, OP_SUB, OP_SBC).
  - A flags struct {cout, ovf, zero, neg}.
  - Default WIDTH/SEG constants.
- **Sub-module `cla_seg`:** SEG-bit combinational CLA built from 4-bit lookahead groups, with outputs sum, cout and carry-into-MSB (the last is needed by the final stage for ovf).
- **Top level:** a generate loop of STAGES register stages around cla_seg, plus the handshake logic.
- **Elaboration checks:** elaboration fails if WIDTH % SEG != 0 or SEG % 4 != 0.

## Test plan
- **ADD with carry propagation:** ADD 0xFFFF_FFFF + 0x0000_0001 -> sum 0x0000_0000, cout 1, zero 1, ovf 0, after 4 cycles.
- **SUB with signed overflow:** SUB 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, ovf 1, cout 1, neg 0. Then SUB 5 - 7 -> 0xFFFF_FFFE, cout 0, neg 1.
- **ADC and SBC carry-in:** ADC 0x7FFF_FFFF + 0 with cin 1 -> 0x8000_0000, ovf 1. SBC 10 - 3 with cin 0 -> 6.
- **Back-to-back with backpressure:**
  - Stream 16 random ops with out_ready toggling pseudo-randomly.
  - Results must match a reference model in order, with no loss or duplication.
  - out_* must be stable while out_valid=1 and out_ready=0.
- **Reset mid-stream:** assert reset with 3 ops in flight -> out_valid 0 next cycle, and no stale result after reset.
- **Parameter sweep:** WIDTH=16/SEG=4 (4 stages) and WIDTH=64/SEG=16 (4 stages), checking latency = STAGES and exhaustive edge operands (0, 1, max, min-signed).
